// File: rtl/score_keeper_pkg.sv
// score_pkg: shared types and constants for the score_keeper slice.
// Optional feature macro: SCORE_HISCORE_EN (adds the hi_score register/port).
package score_pkg;

    // Game state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    // Largest value a single BCD digit may hold
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Width of the lives counter (supports 1..15 lives)
    localparam int LIVES_W = 4;

endpackage : score_pkg

// File: rtl/score_keeper_if.sv
// score_keeper_if: game inputs and scoreboard outputs of score_keeper.
// Optional feature macro: SCORE_HISCORE_EN (adds hi_score to the bundle).
interface score_keeper_if #(
    parameter int DIGITS = 2
);
    import score_pkg::*;

    logic                    start;
    logic                    hit;
    logic                    wrap;
    logic [4*DIGITS-1:0]     score;
    logic [LIVES_W-1:0]      lives;
    logic                    playing;
    logic                    game_over;
`ifdef SCORE_HISCORE_EN
    logic [4*DIGITS-1:0]     hi_score;
`endif

    // Stimulus side: drives the game events, observes the scoreboard
    modport master (
        output start, hit, wrap,
        input  score, lives, playing, game_over
`ifdef SCORE_HISCORE_EN
        , input hi_score
`endif
    );

    // score_keeper side
    modport slave (
        input  start, hit, wrap,
        output score, lives, playing, game_over
`ifdef SCORE_HISCORE_EN
        , output hi_score
`endif
    );

endinterface : score_keeper_if

// File: rtl/score_keeper_bcd_digit.sv
// bcd_digit: one 4-bit BCD counter digit, chained through inc_in/carry_out.
// A digit at 9 rolls to 0 and asserts carry_out in the same cycle as inc_in.
module bcd_digit
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       reset_b,
    input  logic       clr,
    input  logic       inc_in,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [3:0] digit_reg;

    // Digit register: synchronous clear has priority over increment
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            digit_reg <= 4'd0;
        end else if (clr) begin
            digit_reg <= 4'd0;
        end else if (inc_in) begin
            digit_reg <= (digit_reg == BCD_MAX) ? 4'd0 : digit_reg + 4'd1;
        end
    end

    assign digit     = digit_reg;
    assign carry_out = inc_in & (digit_reg == BCD_MAX);

endmodule : bcd_digit

// File: rtl/score_keeper.sv
// score_keeper: play/game-over FSM, one credited hit per sprite pass,
// a life lost per pass without a hit, saturating DIGITS-wide BCD score.
// Optional feature macro: SCORE_HISCORE_EN (best-score register and port).
module score_keeper
    import score_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int LIVES  = 3
) (
    input  logic                 clk,
    input  logic                 reset_b,
    score_keeper_if.slave        bus
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_t               state_reg,    state_next;
    logic [LIVES_W-1:0]   lives_reg,    lives_next;
    logic                 credited_reg, credited_next;
    logic                 hit_q_reg;
    logic                 playing_reg;
    logic                 game_over_reg;

    logic                 hit_edge;
    logic                 credit;
    logic                 score_clr;
    logic                 score_inc;
    logic                 all_nines;
    logic [4*DIGITS-1:0]  score_val;
    logic [DIGITS-1:0]    digit_is_max;
    logic [DIGITS:0]      carry;
    logic                 unused_top_carry;

    assign hit_edge = bus.hit & ~hit_q_reg;

    // Next-state, lives and per-pass credit bookkeeping
    always_comb begin
        state_next    = state_reg;
        lives_next    = lives_reg;
        credited_next = credited_reg;
        score_clr     = 1'b0;
        credit        = 1'b0;
        case (state_reg)
            IDLE, OVER: begin
                if (bus.start) begin
                    score_clr     = 1'b1;
                    lives_next    = LIVES_INIT;
                    credited_next = 1'b0;
                    state_next    = PLAY;
                end
            end
            PLAY: begin
                if (hit_edge && !credited_reg) begin
                    credit        = 1'b1;
                    credited_next = 1'b1;
                end
                if (bus.wrap) begin
                    // A hit credited on this very edge still saves the life
                    credited_next = 1'b0;
                    if (!credited_reg && !credit) begin
                        lives_next = lives_reg - LIVES_W'(1);
                        if (lives_reg == LIVES_W'(1)) begin
                            state_next = OVER;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, lives, credit flag, hit history and registered status flags
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_reg     <= IDLE;
            lives_reg     <= LIVES_INIT;
            credited_reg  <= 1'b0;
            hit_q_reg     <= 1'b0;
            playing_reg   <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lives_reg     <= lives_next;
            credited_reg  <= credited_next;
            hit_q_reg     <= bus.hit;
            playing_reg   <= (state_next == PLAY);
            game_over_reg <= (state_next == OVER);
        end
    end

    // Saturation: stop feeding the chain once every digit reads 9
    assign all_nines = &digit_is_max;
    assign score_inc = credit & ~all_nines;
    assign carry[0]  = score_inc;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk       (clk),
                .reset_b   (reset_b),
                .clr       (score_clr),
                .inc_in    (carry[gi]),
                .digit     (score_val[gi*4 +: 4]),
                .carry_out (carry[gi+1])
            );
            assign digit_is_max[gi] = (score_val[gi*4 +: 4] == BCD_MAX);
        end
    endgenerate

    // The top carry can never assert because saturation blocks it
    assign unused_top_carry = carry[DIGITS];

    assign bus.score     = score_val;
    assign bus.lives     = lives_reg;
    assign bus.playing   = playing_reg;
    assign bus.game_over = game_over_reg;

`ifdef SCORE_HISCORE_EN
    logic [4*DIGITS-1:0] hi_score_reg;

    // Best score captured on the PLAY->OVER edge. That edge is a wrap with
    // no credit, so the score is not changing and score_val is already the
    // post-update value. BCD orders the same as plain binary.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            hi_score_reg <= '0;
        end else if (state_reg == PLAY && state_next == OVER
                     && score_val > hi_score_reg) begin
            hi_score_reg <= score_val;
        end
    end

    assign bus.hi_score = hi_score_reg;
`endif

endmodule : score_keeper

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed plus randomized stimulus for score_keeper,
// checked every cycle against an integer-level game model.
// Optional feature macro: SCORE_HISCORE_EN (also checks hi_score).
module tb_score_keeper;

    localparam int DIGITS = 2;
    localparam int LIVES  = 3;
    localparam int MAXS   = 99;

    logic clk = 1'b0;
    logic reset_b;

    always #10 clk = ~clk;

    score_keeper_if #(.DIGITS(DIGITS)) bus();

    score_keeper #(.DIGITS(DIGITS), .LIVES(LIVES)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    // Reference model: 0 = idle, 1 = playing, 2 = game over
    int m_mode, m_score, m_lives, m_hi;
    bit m_hit_prev, m_cred;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int d;
        d = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    task automatic model_edge(input bit rb, input bit s, input bit h, input bit w);
        bit rise;
        if (!rb) begin
            m_mode = 0; m_score = 0; m_lives = LIVES; m_hi = 0;
            m_cred = 0; m_hit_prev = 0;
        end else begin
            rise = h && !m_hit_prev;
            m_hit_prev = h;
            if (m_mode != 1) begin
                if (s) begin
                    m_mode = 1; m_score = 0; m_lives = LIVES; m_cred = 0;
                end
            end else begin
                if (rise && !m_cred) begin
                    m_cred = 1;
                    if (m_score < MAXS) m_score++;
                end
                if (w) begin
                    if (!m_cred) m_lives--;
                    m_cred = 0;
                    if (m_lives == 0) begin
                        m_mode = 2;
                        if (m_score > m_hi) m_hi = m_score;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("score",     32'(bus.score),     32'(to_bcd(m_score)));
        chk("lives",     32'(bus.lives),     32'(m_lives));
        chk("playing",   32'(bus.playing),   32'(m_mode == 1));
        chk("game_over", 32'(bus.game_over), 32'(m_mode == 2));
`ifdef SCORE_HISCORE_EN
        chk("hi_score",  32'(bus.hi_score),  32'(to_bcd(m_hi)));
`endif
    endtask

    // One clock: drive inputs, take the edge, update model, compare
    task automatic step(input bit rb, input bit s, input bit h, input bit w);
        reset_b  = rb;
        bus.start = s;
        bus.hit   = h;
        bus.wrap  = w;
        @(posedge clk);
        model_edge(rb, s, h, w);
        #1;
        check_all();
    endtask

    // One pass with a single hit pulse, ended by wrap
    task automatic pass_hit();
        step(1, 0, 1, 0);
        step(1, 0, 0, 1);
    endtask

    task automatic lose_game();
        repeat (LIVES) step(1, 0, 0, 1);
    endtask

    bit h_r;

    initial begin
        reset_b = 1'b0; bus.start = 1'b0; bus.hit = 1'b0; bus.wrap = 1'b0;

        // Reset and start
        step(0, 0, 0, 0);
        chk("rst_score", 32'(bus.score), 32'h00);
        chk("rst_lives", 32'(bus.lives), 32'd3);
        step(1, 1, 0, 0);
        chk("start_playing", 32'(bus.playing), 32'd1);

        // Long hit, second edge in the same pass, then wrap
        repeat (10) step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("one_credit_score", 32'(bus.score), 32'h01);
        chk("one_credit_lives", 32'(bus.lives), 32'd3);

        // Three empty passes end the game; further events are ignored
        lose_game();
        chk("over_flag", 32'(bus.game_over), 32'd1);
        step(1, 0, 1, 0);
        step(1, 0, 0, 1);
        chk("over_frozen", 32'(bus.score), 32'h01);
        step(1, 1, 0, 0);
        chk("restart_score", 32'(bus.score), 32'h00);

        // Digit carry and saturation
        repeat (9) pass_hit();
        chk("score_09", 32'(bus.score), 32'h09);
        pass_hit();
        chk("score_10", 32'(bus.score), 32'h10);
        repeat (89) pass_hit();
        chk("score_99", 32'(bus.score), 32'h99);
        pass_hit();
        chk("score_sat", 32'(bus.score), 32'h99);

        // Simultaneous hit edge and wrap
        lose_game();
        step(1, 1, 0, 0);
        step(1, 0, 1, 1);
        chk("simul_score", 32'(bus.score), 32'h01);
        chk("simul_lives", 32'(bus.lives), 32'd3);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        chk("next_pass", 32'(bus.score), 32'h02);

        // Best-score tracking across games, cleared only by reset
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        repeat (5) pass_hit();
        lose_game();
        step(1, 1, 0, 0);
        repeat (3) pass_hit();
        lose_game();
        step(0, 0, 0, 0);

        // Randomized play
        h_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) h_r = ~h_r;
            step(($urandom_range(399) != 0), ($urandom_range(24) == 0),
                 h_r, ($urandom_range(5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_score_keeper

// File: doc/score_keeper.md
# score_keeper

Game-scoring stage downstream of the hit detector, consuming its `hit` output and the sprite-wrap event from the top-level motion counter. Runs the play/game-over state machine, credits at most one hit per sprite pass, deducts a life for each pass that ends without a hit, and keeps a saturating multi-digit BCD score. The BCD score drives the seven-segment `hex_decoder` instances directly, one digit each.

## Interface
Parameters:
- `DIGITS`, 2: number of BCD score digits; the score saturates at all nines.
- `LIVES`, 3: lives granted at game start; must be 1..15.

Ports:
- `clk`, input, 1: system clock (CLOCK_50 domain).
- `reset_b`, input, 1: reset. One clock; reset is synchronous and active-low.
- `start`, input, 1: begin/restart request, level or pulse; acted on in IDLE/OVER only.
- `hit`, input, 1: hit indication from the hit detector, may stay high for many cycles.
- `wrap`, input, 1: single-cycle pulse when the sprite reloads to the right edge (end of pass).
- `score`, output, 4*DIGITS: BCD score, digit 0 in [3:0].
- `lives`, output, 4: remaining lives.
- `playing`, output, 1: high in PLAY.
- `game_over`, output, 1: high in OVER.
- `hi_score`, output, 4*DIGITS: best score, present only with `SCORE_HISCORE_EN`.

## Operation
- States: IDLE, PLAY, OVER. Reset → IDLE, `score`=0, `lives`=LIVES, `playing`=0, `game_over`=0, internal `hit_q`=0 and `credited`=0.
- `hit_q` registers `hit` every cycle in every state. A hit edge is `hit & ~hit_q`.
- IDLE or OVER with `start`=1: `score`←0, `lives`←LIVES, `credited`←0, state←PLAY. In OVER without `start`, `score` and `lives` stay frozen.
- PLAY, `start`: ignored.
- PLAY, hit edge with `credited`=0: increment `score` by one in BCD and set `credited`. Any further edges in the same pass are ignored.
- BCD arithmetic: a digit at 9 rolls to 0 and carries into the next digit. If every digit is 9, the score holds at 9…9 with no wrap to 0.
- PLAY, `wrap`=1:
  - If `credited`=0, `lives`←`lives`−1.
  - `credited` is cleared either way.
  - If the decrement reaches 0, state←OVER in the same edge.
- Simultaneous hit edge and `wrap` in the same cycle, with `credited`=0: the hit is credited, no life is lost, and `credited` ends at 0.
- `wrap` in IDLE or OVER: ignored.
- `reset_b` low mid-game: all state returns to reset values on the next edge. `hi_score` also resets.

## Timing
- All outputs are registered. They update on the same edge at which the triggering input is first sampled; `score`, `lives` and state reflect the event one cycle later.
- `start` sampled on edge N → `playing`=1 after edge N. A `hit` already high at edge N is not credited, because `hit_q` has already tracked it.
- Last life lost on `wrap` at edge N → `game_over`=1 and `playing`=0 after edge N.
- No handshakes; all inputs are synchronous to `clk`.

## Configuration
- `SCORE_HISCORE_EN` defined:
  - Adds the `hi_score` register and port, reset to 0.
  - On the PLAY→OVER transition edge, `hi_score`←`score` if `score` > `hi_score`, using the post-update score from that edge.
  - `start` does not clear `hi_score`.
- `SCORE_HISCORE_EN` undefined: no `hi_score` register, no comparator, no port.

## Structure
- Package `score_pkg`:
  - state enum (IDLE/PLAY/OVER) and its encoding;
  - `BCD_MAX` digit constant (4'd9);
  - lives width constant (4).
- Sub-module `bcd_digit`: one 4-bit BCD digit with `inc_in` and `carry_out`. It is instantiated DIGITS times in a chain.
- The saturation check (all digits 9) lives in `score_keeper`, which gates `inc_in` of digit 0.

## Test plan
- Reset then `start` pulse → `playing`=1, `score`=0x00, `lives`=3 one cycle later.
- `hit` held high for 10 cycles, then `wrap` → `score`=0x01, `lives`=3. A second rising edge of `hit` before `wrap` → `score` still 0x01.
- Three `wrap` pulses with no hits → `lives` goes 2, 1, 0 → `game_over`=1 after the third. Further `hit`/`wrap` leave `score` unchanged. `start` → back in PLAY with `score`=0x00, `lives`=3.
- Credit 9 passes, then a 10th hit → `score` goes 0x09 → 0x10. Preload to 0x99 via hits, then one more hit → `score` stays 0x99.
- Hit edge and `wrap` in the same cycle → `score` increments, `lives` unchanged. Next pass hit is creditable.
- With `SCORE_HISCORE_EN`: game ends at 0x05 → `hi_score`=0x05. Next game ends at 0x03 → `hi_score` stays 0x05. `reset_b`=0 → `hi_score`=0x00.
